regfile_rename: RTL and testbench
=================================

REGFILE_RENAME -- requirements
Module: regfile_rename

Interface
REQ-001 Parameter REG_COUNT, default 32, number of architectural registers; x0 hardwired.
REQ-002 Parameter ROB_W, default 4, reorder-tag width; tag 0 reserved as "no owner".
REQ-003 in_clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 in_rst_n  input  1  reset; asynchronous, active-low.
REQ-005 in_rdy  input  1  global enable; low freezes all state.
REQ-006 in_flush_enable  input  1  mispredict flush from ROB.
REQ-007 in_decoder_rs / in_decoder_rt  input  5 each  source register indices to query.
REQ-008 out_decoder_rs_busy / out_decoder_rt_busy  output  1 each  register awaits in-flight result.
REQ-009 out_decoder_rs_value / out_decoder_rt_value  output  32 each  architectural value.
REQ-010 out_decoder_rs_reorder / out_decoder_rt_reorder  output  ROB_W each  owning ROB tag; 0 when not busy.
REQ-011 in_decoder_rename_enable  input  1  decoder allocates a destination.
REQ-012 in_decoder_rd  input  5  destination register.
REQ-013 in_decoder_reorder  input  ROB_W  ROB tail tag assigned to rd, never 0.
REQ-014 in_rob_commit_enable  input  1  ROB retires a register-writing entry.
REQ-015 in_rob_commit_rd  input  5  retiring destination.
REQ-016 in_rob_commit_value  input  32  retiring result.
REQ-017 in_rob_commit_reorder  input  ROB_W  retiring entry tag.

Function
REQ-018 Queries SHALL be combinational: busy, value, tag of the indexed register; index 0 SHALL return busy=0, value=0, tag=0.
REQ-019 Commit (enable & in_rdy & rd!=0) SHALL write value[rd] at the next edge, regardless of tag.
REQ-020 Commit SHALL clear busy[rd] and set tag[rd]=0 only if tag[rd]==in_rob_commit_reorder; otherwise busy/tag SHALL be unchanged.
REQ-021 Rename (enable & in_rdy & rd!=0 & !flush) SHALL set busy[rd]=1, tag[rd]=in_decoder_reorder.
REQ-022 Same-cycle rename and commit to the same rd: value SHALL be written, busy SHALL stay 1, tag SHALL be the new rename tag.
REQ-023 Same-cycle rename and commit to different registers SHALL both take effect independently.
REQ-024 Flush SHALL clear every busy bit and tag to 0 at the next edge; a same-cycle commit SHALL still write its value; a same-cycle rename SHALL be discarded.
REQ-025 Writes or renames targeting x0 SHALL be ignored.
REQ-026 in_rdy low SHALL suppress commit, rename and flush; outputs SHALL keep reflecting the held state.
REQ-027 Latency: a rename or commit SHALL be visible on query outputs one cycle after its edge (except REQ-030).

Reset
REQ-028 While in_rst_n is low, all values SHALL be 0, all busy bits 0, all tags 0, asynchronously and independent of in_clk.
REQ-029 Reset asserted mid-operation SHALL discard pending rename/commit; first edge after deassertion SHALL behave as a normal cycle.

Configuration
REQ-030 Macro REGFILE_COMMIT_BYPASS_EN defined: when a valid commit (REQ-019) matches a queried register and that register's current tag, the query SHALL return busy=0, tag=0, value=in_rob_commit_value in the same cycle.
REQ-031 Macro undefined: no bypass; queries SHALL reflect registered state only (ROB entry values still cover the gap).

Structure
REQ-032 REG_WIDTH, DATA_WIDTH, ROB_WIDTH, ZERO_DATA and NO_REORDER (=0) SHALL live in the shared definitions header used by rob and decoder.
REQ-033 One sub-module regfile_query_port SHALL implement lookup plus optional bypass mux, instantiated twice (rs, rt).

Verification
REQ-034 Reset: hold in_rst_n low without clocks -> any query returns busy=0, value=0, tag=0.
REQ-035 Rename x5 tag 3, then commit x5 tag 3 value 0xDEADBEEF -> after commit edge x5 busy=0, value=0xDEADBEEF, tag=0.
REQ-036 Rename x5 tag 3, rename x5 tag 7, commit x5 tag 3 value 0x11 -> x5 value=0x11, busy=1, tag=7.
REQ-037 Same cycle rename x6 tag 9 and commit x6 (tag 9 previously owner) value 0x22 -> value=0x22, busy=1, tag=9.
REQ-038 Busy x1,x2,x3 then flush with commit x1 value 0x44 and rename x4 tag 2 -> all busy=0, x1=0x44, x4 not busy.
REQ-039 Rename x0 tag 5 and commit x0 value 0x55 -> x0 query stays busy=0, value=0; with REGFILE_COMMIT_BYPASS_EN, commit x7 tag 1 value 0x66 while querying x7 -> same-cycle busy=0, value=0x66.

Source files
------------

// File: rtl/regfile_rename_pkg.sv
// regfile_rename_pkg: widths and constants shared by the register file, ROB and decoder.
package regfile_rename_pkg;

    localparam int REG_WIDTH  = 5;
    localparam int DATA_WIDTH = 32;
    localparam int ROB_WIDTH  = 4;

    localparam logic [DATA_WIDTH-1:0] ZERO_DATA  = '0;
    localparam logic [ROB_WIDTH-1:0]  NO_REORDER = '0;

endpackage

// File: rtl/regfile_rename_if.sv
// regfile_rename_if: decoder query/rename, ROB commit and flush bundle for the rename register file.
`default_nettype none

interface regfile_rename_if
    import regfile_rename_pkg::*;
#(
    parameter int ROB_W = 4
) ();

    logic                  in_rdy;
    logic                  in_flush_enable;
    logic [REG_WIDTH-1:0]  in_decoder_rs;
    logic [REG_WIDTH-1:0]  in_decoder_rt;
    logic                  out_decoder_rs_busy;
    logic                  out_decoder_rt_busy;
    logic [DATA_WIDTH-1:0] out_decoder_rs_value;
    logic [DATA_WIDTH-1:0] out_decoder_rt_value;
    logic [ROB_W-1:0]      out_decoder_rs_reorder;
    logic [ROB_W-1:0]      out_decoder_rt_reorder;
    logic                  in_decoder_rename_enable;
    logic [REG_WIDTH-1:0]  in_decoder_rd;
    logic [ROB_W-1:0]      in_decoder_reorder;
    logic                  in_rob_commit_enable;
    logic [REG_WIDTH-1:0]  in_rob_commit_rd;
    logic [DATA_WIDTH-1:0] in_rob_commit_value;
    logic [ROB_W-1:0]      in_rob_commit_reorder;

    modport slave (
        input  in_rdy, in_flush_enable, in_decoder_rs, in_decoder_rt,
        input  in_decoder_rename_enable, in_decoder_rd, in_decoder_reorder,
        input  in_rob_commit_enable, in_rob_commit_rd, in_rob_commit_value, in_rob_commit_reorder,
        output out_decoder_rs_busy, out_decoder_rt_busy,
        output out_decoder_rs_value, out_decoder_rt_value,
        output out_decoder_rs_reorder, out_decoder_rt_reorder
    );

    modport master (
        output in_rdy, in_flush_enable, in_decoder_rs, in_decoder_rt,
        output in_decoder_rename_enable, in_decoder_rd, in_decoder_reorder,
        output in_rob_commit_enable, in_rob_commit_rd, in_rob_commit_value, in_rob_commit_reorder,
        input  out_decoder_rs_busy, out_decoder_rt_busy,
        input  out_decoder_rs_value, out_decoder_rt_value,
        input  out_decoder_rs_reorder, out_decoder_rt_reorder
    );

endinterface

`default_nettype wire

// File: rtl/regfile_query_port.sv
// regfile_query_port: one combinational read port; REGFILE_COMMIT_BYPASS_EN adds a same-cycle commit bypass.
`default_nettype none

module regfile_query_port
    import regfile_rename_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int ROB_W     = 4
) (
    input  wire logic [REG_WIDTH-1:0]  idx_i,
    input  wire logic [DATA_WIDTH-1:0] value_i [REG_COUNT],
    input  wire logic [REG_COUNT-1:0]  busy_i,
    input  wire logic [ROB_W-1:0]      tag_i   [REG_COUNT],
`ifdef REGFILE_COMMIT_BYPASS_EN
    input  wire logic                  commit_valid_i,
    input  wire logic [REG_WIDTH-1:0]  commit_rd_i,
    input  wire logic [DATA_WIDTH-1:0] commit_value_i,
    input  wire logic [ROB_W-1:0]      commit_reorder_i,
`endif
    output logic                       busy_o,
    output logic [DATA_WIDTH-1:0]      value_o,
    output logic [ROB_W-1:0]           tag_o
);

    always_comb begin
        busy_o  = 1'b0;
        value_o = ZERO_DATA;
        tag_o   = '0;
        if (idx_i != '0 && int'(idx_i) < REG_COUNT) begin
            busy_o  = busy_i[idx_i];
            value_o = value_i[idx_i];
            tag_o   = tag_i[idx_i];
`ifdef REGFILE_COMMIT_BYPASS_EN
            // Only the commit that retires the current owner releases the register early.
            if (commit_valid_i && commit_rd_i == idx_i && tag_i[idx_i] == commit_reorder_i) begin
                busy_o  = 1'b0;
                value_o = commit_value_i;
                tag_o   = '0;
            end
`endif
        end
    end

endmodule

`default_nettype wire

// File: rtl/regfile_rename.sv
// regfile_rename: architectural register file with busy/ROB-tag rename state; REGFILE_COMMIT_BYPASS_EN enables commit bypass.
`default_nettype none

module regfile_rename
    import regfile_rename_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter int ROB_W     = 4
) (
    input  wire logic      in_clk,
    input  wire logic      in_rst_n,
    regfile_rename_if.slave bus
);

    logic [DATA_WIDTH-1:0] value_q [REG_COUNT];
    logic [DATA_WIDTH-1:0] value_d [REG_COUNT];
    logic [REG_COUNT-1:0]  busy_q;
    logic [REG_COUNT-1:0]  busy_d;
    logic [ROB_W-1:0]      tag_q   [REG_COUNT];
    logic [ROB_W-1:0]      tag_d   [REG_COUNT];

    logic commit_v;
    logic rename_v;
    logic flush_v;

    assign commit_v = bus.in_rob_commit_enable && bus.in_rdy && (bus.in_rob_commit_rd != '0);
    assign rename_v = bus.in_decoder_rename_enable && bus.in_rdy && (bus.in_decoder_rd != '0)
                      && !bus.in_flush_enable;
    assign flush_v  = bus.in_flush_enable && bus.in_rdy;

    // Priority per register: commit release, then rename claim, then flush clear.
    always_comb begin
        value_d = value_q;
        busy_d  = busy_q;
        tag_d   = tag_q;
        for (int i = 1; i < REG_COUNT; i++) begin
            if (commit_v && bus.in_rob_commit_rd == REG_WIDTH'(i)) begin
                value_d[i] = bus.in_rob_commit_value;
                if (tag_q[i] == bus.in_rob_commit_reorder) begin
                    busy_d[i] = 1'b0;
                    tag_d[i]  = '0;
                end
            end
            if (rename_v && bus.in_decoder_rd == REG_WIDTH'(i)) begin
                busy_d[i] = 1'b1;
                tag_d[i]  = bus.in_decoder_reorder;
            end
            if (flush_v) begin
                busy_d[i] = 1'b0;
                tag_d[i]  = '0;
            end
        end
    end

    always_ff @(posedge in_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            busy_q <= '0;
            for (int i = 0; i < REG_COUNT; i++) begin
                value_q[i] <= ZERO_DATA;
                tag_q[i]   <= '0;
            end
        end else begin
            busy_q  <= busy_d;
            value_q <= value_d;
            tag_q   <= tag_d;
        end
    end

    regfile_query_port #(
        .REG_COUNT (REG_COUNT),
        .ROB_W     (ROB_W)
    ) u_query_rs (
        .idx_i            (bus.in_decoder_rs),
        .value_i          (value_q),
        .busy_i           (busy_q),
        .tag_i            (tag_q),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_valid_i   (commit_v),
        .commit_rd_i      (bus.in_rob_commit_rd),
        .commit_value_i   (bus.in_rob_commit_value),
        .commit_reorder_i (bus.in_rob_commit_reorder),
`endif
        .busy_o           (bus.out_decoder_rs_busy),
        .value_o          (bus.out_decoder_rs_value),
        .tag_o            (bus.out_decoder_rs_reorder)
    );

    regfile_query_port #(
        .REG_COUNT (REG_COUNT),
        .ROB_W     (ROB_W)
    ) u_query_rt (
        .idx_i            (bus.in_decoder_rt),
        .value_i          (value_q),
        .busy_i           (busy_q),
        .tag_i            (tag_q),
`ifdef REGFILE_COMMIT_BYPASS_EN
        .commit_valid_i   (commit_v),
        .commit_rd_i      (bus.in_rob_commit_rd),
        .commit_value_i   (bus.in_rob_commit_value),
        .commit_reorder_i (bus.in_rob_commit_reorder),
`endif
        .busy_o           (bus.out_decoder_rt_busy),
        .value_o          (bus.out_decoder_rt_value),
        .tag_o            (bus.out_decoder_rt_reorder)
    );

endmodule

`default_nettype wire

// File: tb/tb_regfile_rename.sv
// tb_regfile_rename: directed scoreboard bench; expectations follow REGFILE_COMMIT_BYPASS_EN when defined.
`default_nettype none

module tb_regfile_rename;

    logic clk    = 1'b0;
    logic clk_en = 1'b0;
    logic rst_n  = 1'b0;
    logic probe  = 1'b0;

    int checks = 0;
    int errors = 0;

    always #5 if (clk_en) clk = ~clk;

    regfile_rename_if #(.ROB_W(4)) bus ();

    regfile_rename #(
        .REG_COUNT (32),
        .ROB_W     (4)
    ) dut (
        .in_clk   (clk),
        .in_rst_n (rst_n),
        .bus      (bus)
    );

    typedef struct {
        logic [95:0] name;
        logic        b0;
        logic [31:0] v0;
        logic [3:0]  t0;
        logic        b1;
        logic [31:0] v1;
        logic [3:0]  t1;
    } exp_t;

    exp_t q[$];

    task automatic cmp(input logic [95:0] nm, input logic [63:0] what, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %0s %0s: got %h expected %h", nm, what, act, exp);
        end
    endtask

    // Monitor: the query outputs are valid at every falling edge (or an explicit probe while clocks are off).
    initial begin
        forever begin
            @(negedge clk or posedge probe);
            while (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                cmp(e.name, "rs_busy", {31'd0, bus.out_decoder_rs_busy}, {31'd0, e.b0});
                cmp(e.name, "rs_val",  bus.out_decoder_rs_value, e.v0);
                cmp(e.name, "rs_tag",  {28'd0, bus.out_decoder_rs_reorder}, {28'd0, e.t0});
                cmp(e.name, "rt_busy", {31'd0, bus.out_decoder_rt_busy}, {31'd0, e.b1});
                cmp(e.name, "rt_val",  bus.out_decoder_rt_value, e.v1);
                cmp(e.name, "rt_tag",  {28'd0, bus.out_decoder_rt_reorder}, {28'd0, e.t1});
            end
        end
    end

    task automatic drv(input logic ren, input logic [4:0] rd, input logic [3:0] rtag,
                       input logic com, input logic [4:0] crd, input logic [31:0] cval,
                       input logic [3:0] ctag, input logic fl, input logic rdy);
        bus.in_decoder_rename_enable = ren;
        bus.in_decoder_rd            = rd;
        bus.in_decoder_reorder       = rtag;
        bus.in_rob_commit_enable     = com;
        bus.in_rob_commit_rd         = crd;
        bus.in_rob_commit_value      = cval;
        bus.in_rob_commit_reorder    = ctag;
        bus.in_flush_enable          = fl;
        bus.in_rdy                   = rdy;
    endtask

    task automatic idle();
        drv(1'b0, 5'd0, 4'd0, 1'b0, 5'd0, 32'd0, 4'd0, 1'b0, 1'b1);
    endtask

    task automatic expq(input logic [95:0] nm,
                        input logic [4:0] rs, input logic b0, input logic [31:0] v0, input logic [3:0] t0,
                        input logic [4:0] rt, input logic b1, input logic [31:0] v1, input logic [3:0] t1);
        exp_t e;
        bus.in_decoder_rs = rs;
        bus.in_decoder_rt = rt;
        e.name = nm;
        e.b0 = b0; e.v0 = v0; e.t0 = t0;
        e.b1 = b1; e.v1 = v1; e.t1 = t1;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        // Reset held, no clock running; a pending rename must not matter.
        drv(1'b1, 5'd5, 4'd3, 1'b1, 5'd5, 32'h1234, 4'd3, 1'b0, 1'b1);
        #3;
        expq("reset", 5'd5, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        probe = 1'b1;
        #1 probe = 1'b0;
        idle();
        #1 rst_n = 1'b1;
        #1 clk_en = 1'b1;
        tick();

        // Rename then matching commit
        drv(1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x5", 5'd5, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("busy_x5", 5'd5, 1, 32'h0, 4'd3, 5'd6, 0, 32'h0, 4'd0);
        tick();
        drv(1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'hDEADBEEF, 4'd3, 1'b0, 1'b1);
        expq("com_x5", 5'd1, 0, 32'h0, 4'd0, 5'd2, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("done_x5", 5'd5, 0, 32'hDEADBEEF, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();

        // Stale commit leaves newer owner in place
        drv(1'b1, 5'd5, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren3_x5", 5'd3, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b1, 5'd5, 4'd7, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren7_x5", 5'd5, 1, 32'hDEADBEEF, 4'd3, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b0, 5'd0, 4'd0, 1'b1, 5'd5, 32'h11, 4'd3, 1'b0, 1'b1);
        expq("stale_cyc", 5'd5, 1, 32'hDEADBEEF, 4'd7, 5'd6, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("stale_x5", 5'd5, 1, 32'h11, 4'd7, 5'd0, 0, 32'h0, 4'd0);
        tick();

        // Same-cycle rename and commit on x6
        drv(1'b1, 5'd6, 4'd9, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x6", 5'd6, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b1, 5'd6, 4'd9, 1'b1, 5'd6, 32'h22, 4'd9, 1'b0, 1'b1);
        expq("rc_cyc", 5'd5, 1, 32'h11, 4'd7, 5'd0, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("rc_x6", 5'd6, 1, 32'h22, 4'd9, 5'd5, 1, 32'h11, 4'd7);
        tick();

        // Rename and commit to different registers
        drv(1'b1, 5'd8, 4'd6, 1'b1, 5'd5, 32'h33, 4'd7, 1'b0, 1'b1);
        expq("indep_cyc", 5'd6, 1, 32'h22, 4'd9, 5'd8, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("indep", 5'd5, 0, 32'h33, 4'd0, 5'd8, 1, 32'h0, 4'd6);
        tick();

        // Flush with same-cycle commit and rename
        drv(1'b1, 5'd1, 4'd1, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x1", 5'd1, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b1, 5'd2, 4'd2, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x2", 5'd1, 1, 32'h0, 4'd1, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b1, 5'd3, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x3", 5'd2, 1, 32'h0, 4'd2, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b1, 5'd4, 4'd2, 1'b1, 5'd1, 32'h44, 4'd1, 1'b1, 1'b1);
        expq("flush_cyc", 5'd3, 1, 32'h0, 4'd3, 5'd4, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("flush_a", 5'd1, 0, 32'h44, 4'd0, 5'd4, 0, 32'h0, 4'd0);
        tick();
        expq("flush_b", 5'd3, 0, 32'h0, 4'd0, 5'd8, 0, 32'h0, 4'd0);
        tick();

        // x0 writes and renames ignored
        drv(1'b1, 5'd0, 4'd5, 1'b1, 5'd0, 32'h55, 4'd5, 1'b0, 1'b1);
        expq("x0_cyc", 5'd0, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("x0", 5'd0, 0, 32'h0, 4'd0, 5'd5, 0, 32'h33, 4'd0);
        tick();

        // in_rdy low freezes rename, commit and flush
        drv(1'b1, 5'd9, 4'd4, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x9", 5'd9, 0, 32'h0, 4'd0, 5'd0, 0, 32'h0, 4'd0);
        tick();
        drv(1'b1, 5'd10, 4'd8, 1'b1, 5'd9, 32'h77, 4'd4, 1'b1, 1'b0);
        expq("rdy0_cyc", 5'd9, 1, 32'h0, 4'd4, 5'd10, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("rdy0", 5'd9, 1, 32'h0, 4'd4, 5'd10, 0, 32'h0, 4'd0);
        tick();

        // Commit while querying the committing register
        drv(1'b1, 5'd7, 4'd1, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("ren_x7", 5'd7, 0, 32'h0, 4'd0, 5'd9, 1, 32'h0, 4'd4);
        tick();
        drv(1'b0, 5'd0, 4'd0, 1'b1, 5'd7, 32'h66, 4'd1, 1'b0, 1'b1);
`ifdef REGFILE_COMMIT_BYPASS_EN
        expq("bypass", 5'd7, 0, 32'h66, 4'd0, 5'd9, 1, 32'h0, 4'd4);
`else
        expq("nobypass", 5'd7, 1, 32'h0, 4'd1, 5'd9, 1, 32'h0, 4'd4);
`endif
        tick();
        idle();
        expq("com_x7", 5'd7, 0, 32'h66, 4'd0, 5'd9, 1, 32'h0, 4'd4);
        tick();

        // Asynchronous reset mid-cycle discards the pending rename
        drv(1'b1, 5'd11, 4'd5, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        #1 rst_n = 1'b0;
        expq("async_rst", 5'd7, 0, 32'h0, 4'd0, 5'd9, 0, 32'h0, 4'd0);
        tick();
        rst_n = 1'b1;
        drv(1'b1, 5'd12, 4'd3, 1'b0, 5'd0, 32'h0, 4'd0, 1'b0, 1'b1);
        expq("post_rst", 5'd11, 0, 32'h0, 4'd0, 5'd12, 0, 32'h0, 4'd0);
        tick();
        idle();
        expq("first_edge", 5'd12, 1, 32'h0, 4'd3, 5'd11, 0, 32'h0, 4'd0);
        tick();
        tick();

        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d unchecked entries expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
